// File: rtl/uart_alu_engine.sv
// Purpose : packet ALU between the UART RX byte stream and the UART TX byte stream (ECHO/ADD/MUL/DIV).
// Latency : ECHO is combinational; ADD 1 cycle per operand, MUL/DIV 8*OPERAND_BYTES cycles per operand; reply bytes follow EXEC.
// Backpress: s_axis_tready is low in EXEC/SEND (no byte is dropped); SEND holds m_axis_tdata until m_axis_tready.
//
// Ports: clk_i/rst_ni (async active-low), s_axis_* RX bytes in, m_axis_* TX bytes out,
//        busy_o (state != OPCODE), div0_o (one-cycle pulse on divide by zero).
// Build option: define UART_ALU_DIV_EN to compile in the divider; otherwise opcode 0x03 is drained
//        like any unknown opcode and div0_o is tied low.
module uart_alu_engine #(
    parameter int OPERAND_BYTES = 4,
    parameter int LEN_WIDTH     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy_o,
    output logic       div0_o
);
    localparam int OW = 8 * OPERAND_BYTES;
    localparam int BW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
    localparam int CW = $clog2(OW);
    localparam logic [7:0]    OP_ADD    = 8'h01;
    localparam logic [7:0]    OP_MUL    = 8'h02;
    localparam logic [7:0]    OP_ECHO   = 8'hEC;
    localparam logic [BW-1:0] LAST_BYTE = BW'(OPERAND_BYTES - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(OW - 1);

    typedef enum logic [3:0] {
        ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO, ST_LOAD, ST_EXEC, ST_SEND, ST_DRAIN
    } state_t;

    state_t               r_state, w_next;
    logic [7:0]           r_opcode, r_len_lo;
    logic [LEN_WIDTH-1:0] r_len;        // payload bytes still to accept
    logic [OW-1:0]        r_opnd, r_acc, r_work;
    logic [BW-1:0]        r_bcnt;       // byte index within operand (LOAD) or reply (SEND)
    logic [CW-1:0]        r_cnt;        // MUL/DIV iteration step
    logic                 r_first;      // next EXEC loads the accumulator
    logic                 r_started;    // holds tready low until the first edge after reset release

    logic                 w_s_fire, w_m_fire, w_last_pay, w_opnd_done, w_exec_done;
    logic                 w_is_div, w_is_alu, w_div0;
    logic [15:0]          w_len_full, w_payload;
    logic [CW-1:0]        w_bit_idx;
    logic [OW-1:0]        w_mul_next;
    logic [7:0]           w_send_byte;

    assign w_s_fire    = s_axis_tvalid & s_axis_tready;
    assign w_m_fire    = m_axis_tvalid & m_axis_tready;
    assign w_len_full  = {s_axis_tdata, r_len_lo};
    assign w_payload   = (w_len_full > 16'd4) ? (w_len_full - 16'd4) : 16'd0;
    assign w_last_pay  = (r_len == LEN_WIDTH'(1));
    assign w_opnd_done = (r_bcnt == LAST_BYTE) || w_last_pay;
    assign w_send_byte = r_acc[{r_bcnt, 3'b000} +: 8];
    assign busy_o      = (r_state != ST_OPCODE);

    // MUL and DIV both walk the operand/dividend MSB-first.
    assign w_bit_idx   = LAST_STEP - r_cnt;
    assign w_mul_next  = {r_work[OW-2:0], 1'b0} + (r_opnd[w_bit_idx] ? r_acc : '0);

`ifdef UART_ALU_DIV_EN
    logic [OW-1:0] r_rem;
    logic          r_div0;
    logic [OW:0]   w_rem_sh;
    logic          w_ge;
    logic [OW-1:0] w_rem_next, w_q_next;

    assign w_is_div   = (r_opcode == 8'h03);
    assign w_rem_sh   = {r_rem, r_acc[w_bit_idx]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_next = w_ge ? OW'(w_rem_sh - {1'b0, r_opnd}) : OW'(w_rem_sh);
    assign w_q_next   = {r_work[OW-2:0], w_ge};
    assign div0_o     = r_div0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rem  <= '0;
            r_div0 <= 1'b0;
        end else begin
            r_div0 <= (r_state == ST_EXEC) && !r_first && w_div0;
            if (r_state == ST_LOAD && w_s_fire && w_opnd_done)
                r_rem <= '0;
            else if (r_state == ST_EXEC && !r_first && w_is_div && !w_div0)
                r_rem <= w_rem_next;
        end
    end
`else
    assign w_is_div = 1'b0;
    assign div0_o   = 1'b0;
`endif

    assign w_is_alu    = (r_opcode == OP_ADD) || (r_opcode == OP_MUL) || w_is_div;
    assign w_div0      = w_is_div && (r_opnd == '0);
    assign w_exec_done = r_first || !((r_opcode == OP_MUL) || (w_is_div && !w_div0)) ||
                         (r_cnt == LAST_STEP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_OPCODE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = w_send_byte;
        case (r_state)
            ST_OPCODE: begin
                s_axis_tready = r_started;
                if (w_s_fire) w_next = ST_RSVD;
            end
            ST_RSVD: begin
                s_axis_tready = 1'b1;
                if (w_s_fire) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                s_axis_tready = 1'b1;
                if (w_s_fire) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                s_axis_tready = 1'b1;
                if (w_s_fire) begin
                    if (w_payload == 16'd0)       w_next = w_is_alu ? ST_SEND : ST_OPCODE;
                    else if (r_opcode == OP_ECHO) w_next = ST_ECHO;
                    else if (w_is_alu)            w_next = ST_LOAD;
                    else                          w_next = ST_DRAIN;
                end
            end
            ST_ECHO: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (w_s_fire && w_last_pay) w_next = ST_OPCODE;
            end
            ST_LOAD: begin
                s_axis_tready = 1'b1;
                if (w_s_fire && w_opnd_done) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_exec_done) w_next = (r_len != '0) ? ST_LOAD : ST_SEND;
            end
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                if (w_m_fire && r_bcnt == LAST_BYTE) w_next = ST_OPCODE;
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (w_s_fire && w_last_pay) w_next = ST_OPCODE;
            end
            default: w_next = ST_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode  <= '0;
            r_len_lo  <= '0;
            r_len     <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_work    <= '0;
            r_bcnt    <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_OPCODE: if (w_s_fire) r_opcode <= s_axis_tdata;
                ST_LEN_LO: if (w_s_fire) r_len_lo <= s_axis_tdata;
                ST_LEN_HI: if (w_s_fire) begin
                    r_len   <= LEN_WIDTH'(w_payload);
                    r_acc   <= '0;   // a zero-payload ALU packet replies with 0
                    r_opnd  <= '0;
                    r_bcnt  <= '0;
                    r_first <= 1'b1;
                end
                ST_ECHO, ST_DRAIN: if (w_s_fire) r_len <= r_len - LEN_WIDTH'(1);
                ST_LOAD: if (w_s_fire) begin
                    // r_opnd is cleared before each operand, so OR-ing in place zero-extends a short one.
                    r_opnd <= r_opnd | (OW'(s_axis_tdata) << {r_bcnt, 3'b000});
                    r_len  <= r_len - LEN_WIDTH'(1);
                    r_bcnt <= r_bcnt + BW'(1);
                    if (w_opnd_done) begin
                        r_cnt  <= '0;
                        r_work <= '0;
                    end
                end
                ST_EXEC: begin
                    if (r_first) begin
                        r_acc   <= r_opnd;
                        r_first <= 1'b0;
                    end else if (r_opcode == OP_ADD) begin
                        r_acc <= r_acc + r_opnd;
                    end else if (r_opcode == OP_MUL) begin
                        r_work <= w_mul_next;
                        r_cnt  <= r_cnt + CW'(1);
                        if (r_cnt == LAST_STEP) r_acc <= w_mul_next;
                    end
`ifdef UART_ALU_DIV_EN
                    else if (w_div0) begin
                        r_acc <= '1;
                    end else begin
                        r_work <= w_q_next;
                        r_cnt  <= r_cnt + CW'(1);
                        if (r_cnt == LAST_STEP) r_acc <= w_q_next;
                    end
`endif
                    if (w_exec_done) begin
                        r_opnd <= '0;
                        r_bcnt <= '0;
                    end
                end
                ST_SEND: if (w_m_fire) r_bcnt <= r_bcnt + BW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_engine.sv
// Bench for uart_alu_engine (OPERAND_BYTES=4): directed packets, resets mid-MUL and mid-SEND,
// then random packets; every reply is compared with a packet-level reference model.
module tb_uart_alu_engine;
    typedef logic [7:0] u8_t;

`ifdef UART_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, s_tvalid, s_tready, m_tvalid, m_tready, busy, div0;
    logic [7:0] s_tdata, m_tdata;
    bit drv_done;
    int n_checks = 0;
    int n_errors = 0;

    uart_alu_engine #(.OPERAND_BYTES(4), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy_o(busy), .div0_o(div0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: parse header, split payload into zero-extended LE words, fold.
    function automatic void model(input u8_t pkt[$], output u8_t exp[$], output int n_div0);
        int len, pay, nops;
        logic [31:0] acc, v;
        u8_t op;
        exp = {};
        n_div0 = 0;
        op  = pkt[0];
        len = int'({pkt[3], pkt[2]});
        pay = (len > 4) ? len - 4 : 0;
        if (op == 8'hEC) begin
            for (int i = 0; i < pay; i++) exp.push_back(pkt[4+i]);
        end else if (op == 8'h01 || op == 8'h02 || (op == 8'h03 && DIV_EN)) begin
            acc  = 0;
            nops = (pay + 3) / 4;
            for (int k = 0; k < nops; k++) begin
                v = 0;
                for (int j = 0; j < 4; j++)
                    if (4*k + j < pay) v = v | (32'(pkt[4 + 4*k + j]) << (8*j));
                if (k == 0)            acc = v;
                else if (op == 8'h01)  acc = acc + v;
                else if (op == 8'h02)  acc = acc * v;
                else if (v == 0) begin acc = 32'hFFFF_FFFF; n_div0++; end
                else                   acc = acc / v;
            end
            for (int j = 0; j < 4; j++) exp.push_back(u8_t'(acc >> (8*j)));
        end
    endfunction

    task automatic drive(input u8_t pkt[$], input bit gaps, output bit tmo);
        tmo = 1'b0;
        foreach (pkt[i]) begin
            int  wait_cyc = 0;
            bit  took = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin s_tvalid = 1'b0; @(posedge clk); #1; end
            s_tdata  = pkt[i];
            s_tvalid = 1'b1;
            while (!took && !tmo) begin
                @(negedge clk);
                took = s_tready;
                @(posedge clk); #1;
                wait_cyc++;
                if (wait_cyc > 2000) tmo = 1'b1;
            end
            s_tvalid = 1'b0;
            if (tmo) break;
        end
        drv_done = 1'b1;
    endtask

    task automatic collect(output u8_t got[$], output int max_low, output int n_div0, output bit tmo);
        int idle = 0, run = 0, cyc = 0;
        got = {}; max_low = 0; n_div0 = 0; tmo = 1'b0;
        while (1) begin
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_tvalid && m_tready) got.push_back(m_tdata);
            if (div0) n_div0++;
            if (busy && !s_tready) begin run++; if (run > max_low) max_low = run; end
            else run = 0;
            idle = (drv_done && !busy) ? idle + 1 : 0;
            @(posedge clk); #1;
            cyc++;
            if (idle >= 4) break;
            if (cyc >= 8000) begin tmo = 1'b1; break; end
        end
        m_tready = 1'b0;
    endtask

    task automatic run_packet(input string tag, input u8_t pkt[$], output int max_low);
        u8_t exp[$], got[$];
        int  exp_d0, got_d0;
        bit  tmo_d, tmo_c;
        model(pkt, exp, exp_d0);
        drv_done = 1'b0;
        fork
            drive(pkt, 1'b1, tmo_d);
            collect(got, max_low, got_d0, tmo_c);
        join
        chk({tag, "_timeout"}, 32'(tmo_d | tmo_c), 32'd0);
        chk({tag, "_count"}, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
        chk({tag, "_div0"}, got_d0, exp_d0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tready"}, 32'(s_tready), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        u8_t p[$], q[$];
        int  ml, w;
        bit  tmo;
        u8_t ops[5];
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; drv_done = 1'b0;
        #12;
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        #10 rst_n = 1'b1;
        #1 chk("release_tready_low", 32'(s_tready), 32'd0);
        @(posedge clk); #1;
        chk("first_edge_tready", 32'(s_tready), 32'd1);

        p = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_packet("echo", p, ml);
        p = {8'h01, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_packet("add_wrap", p, ml);
        p = {8'h01, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        run_packet("add_partial", p, ml);
        p = {8'h02, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
             8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_packet("mul", p, ml);
        chk("mul_stall_ge32", 32'(ml >= 32), 32'd1);
        p = {8'h03, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_packet("div", p, ml);
        p = {8'h03, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_packet("div0", p, ml);
        p = {8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_packet("unknown", p, ml);
        p = {8'h01, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h01, 8'h01, 8'h01};
        run_packet("add_after_unknown", p, ml);
        p = {8'h01, 8'h00, 8'h02, 8'h00};
        run_packet("add_len2", p, ml);

        // Reset while the multiplier is iterating.
        m_tready = 1'b1;
        drv_done = 1'b0;
        p = {8'h02, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        drive(p, 1'b0, tmo);
        chk("rstmul_drive_timeout", 32'(tmo), 32'd0);
        repeat (10) @(posedge clk);
        #1 chk("rstmul_busy_before", 32'(busy), 32'd1);
        pulse_reset("rst_mid_mul");

        // Reset while a reply is stalled by the sink.
        m_tready = 1'b0;
        drv_done = 1'b0;
        p = {8'h01, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        drive(p, 1'b0, tmo);
        w = 0;
        while (!m_tvalid && w < 200) begin @(posedge clk); #1; w++; end
        chk("rstsend_tvalid_before", 32'(m_tvalid), 32'd1);
        chk("rstsend_hold_byte0", m_tdata, 32'h01);
        pulse_reset("rst_mid_send");
        run_packet("add_after_reset", p, ml);

        ops = '{8'hEC, 8'h01, 8'h02, 8'h03, 8'h55};
        for (int n = 0; n < 14; n++) begin
            int pay, len;
            pay = $urandom_range(0, 11);
            len = (pay == 0) ? $urandom_range(0, 4) : pay + 4;
            q = {ops[$urandom_range(0, 4)], u8_t'($urandom), u8_t'(len), u8_t'(len >> 8)};
            for (int i = 0; i < pay; i++)
                q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 :
                            ($urandom_range(0, 1) == 1) ? u8_t'($urandom) : u8_t'($urandom_range(1, 9)));
            run_packet($sformatf("rand%0d_op%02h", n, q[0]), q, ml);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
